// File: rtl/axis_stall_detector_pkg.sv
// Shared types and helpers for the AXI-Stream stall detector.
// Holds the per-channel FSM state encoding and the stall-condition rule.
package axis_stall_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BLOCKED = 2'd2
    } stall_state_t;

    localparam int DEF_CNT_W = 8;

    // A transfer (valid & ready) is never a stall in either direction.
    function automatic logic stall_cond(input logic is_out, input logic valid,
                                        input logic ready, input logic en);
        return en & (is_out ? (valid & ~ready) : (ready & ~valid));
    endfunction

endpackage

// File: rtl/axis_stall_detector_if.sv
// Per-channel TVALID/TREADY/enable bundle observed by the stall detector.
// The master side is the stream environment; the detector only listens.
interface axis_stall_detector_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] tvalid;
    logic [NUM_CH-1:0] tready;

    modport master (output enable, output tvalid, output tready);
    modport slave  (input  enable, input  tvalid, input  tready);
endinterface

// File: rtl/axis_stall_detector_chan.sv
// One stream channel: IDLE/WAIT/BLOCKED FSM, stall-run counter and, when
// AXIS_STALL_HIST_EN is defined, the longest-run history register.
module axis_stall_chan
    import axis_stall_pkg::*;
#(
    parameter bit IS_OUT       = 1'b0,
    parameter int STALL_THRESH = 4,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             tvalid,
    input  logic             tready,
    output logic             block,
    output logic             block_nxt,
    output logic [CNT_W-1:0] max_stall
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

    stall_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             stall;
    logic             flush;

    assign flush = reset | clear;
    assign stall = stall_cond(IS_OUT, tvalid, tready, enable);

    // Exposed so the top can register any_block in step with block.
    assign block_nxt = ~flush & stall &
                       ((state == BLOCKED) ||
                        (state == WAIT && cnt == THRESH_M1) ||
                        (state == IDLE && STALL_THRESH == 1));

    always_ff @(posedge clock) begin
        block <= block_nxt;
        if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        cnt   <= CNT_W'(1);
                        state <= (STALL_THRESH == 1) ? BLOCKED : WAIT;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    if (stall) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == THRESH_M1) state <= BLOCKED;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                BLOCKED: begin
                    if (stall) begin
                        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef AXIS_STALL_HIST_EN
    logic [CNT_W-1:0] max_q;

    // cnt never exceeds CNT_MAX, so the history saturates on its own.
    always_ff @(posedge clock) begin
        if (flush) begin
            max_q <= '0;
        end else if ((state == BLOCKED) || (state == WAIT && !stall)) begin
            if (cnt > max_q) max_q <= cnt;
        end
    end

    assign max_stall = max_q;
`else
    assign max_stall = '0;
`endif

endmodule

// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall detector feeding the deadlock monitor.
// Define AXIS_STALL_HIST_EN to build the per-channel max_stall history.
module axis_stall_detector
    import axis_stall_pkg::*;
#(
    parameter int                NUM_CH       = 2,
    parameter logic [NUM_CH-1:0] CH_IS_OUT    = 2'b10,
    parameter int                STALL_THRESH = 4,
    parameter int                CNT_W        = DEF_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    axis_stall_detector_if.slave    mon,
    output logic [NUM_CH-1:0]       axis_block_sigs,
    output logic                    any_block,
    output logic [NUM_CH*CNT_W-1:0] max_stall
);

    logic [NUM_CH-1:0] block_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        axis_stall_chan #(
            .IS_OUT      (CH_IS_OUT[g]),
            .STALL_THRESH(STALL_THRESH),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .clear    (clear),
            .enable   (mon.enable[g]),
            .tvalid   (mon.tvalid[g]),
            .tready   (mon.tready[g]),
            .block    (axis_block_sigs[g]),
            .block_nxt(block_nxt[g]),
            .max_stall(max_stall[g*CNT_W +: CNT_W])
        );
    end

    // Built from next-state bits so it lands on the same edge as the blocks.
    always_ff @(posedge clock) begin
        if (reset || clear) any_block <= 1'b0;
        else                any_block <= |block_nxt;
    end

endmodule

// File: tb/tb_axis_stall_detector.sv
// Scoreboard bench: two detectors (threshold 4 / CNT_W 4, threshold 1 / CNT_W 8)
// share one stimulus stream; a run-length model predicts every output cycle.
module tb_axis_stall_detector;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;
    logic clear = 1'b0;

    axis_stall_detector_if #(.NUM_CH(2)) bus();

    logic [1:0]  blk_a, blk_b;
    logic        any_a, any_b;
    logic [7:0]  max_a;
    logic [15:0] max_b;

    axis_stall_detector #(.NUM_CH(2), .CH_IS_OUT(2'b10), .STALL_THRESH(4), .CNT_W(4)) dut_a (
        .clock(clock), .reset(reset), .clear(clear), .mon(bus),
        .axis_block_sigs(blk_a), .any_block(any_a), .max_stall(max_a));

    axis_stall_detector #(.NUM_CH(2), .CH_IS_OUT(2'b10), .STALL_THRESH(1), .CNT_W(8)) dut_b (
        .clock(clock), .reset(reset), .clear(clear), .mon(bus),
        .axis_block_sigs(blk_b), .any_block(any_b), .max_stall(max_b));

    typedef struct packed {
        logic [1:0]  blk_a;
        logic        any_a;
        logic [7:0]  max_a;
        logic [1:0]  blk_b;
        logic        any_b;
        logic [15:0] max_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   run[2]  = '{0, 0};
    int   mx_a[2] = '{0, 0};
    int   mx_b[2] = '{0, 0};

    initial begin
        bus.enable = 2'b00;
        bus.tvalid = 2'b00;
        bus.tready = 2'b00;
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: a channel's run is the number of consecutive stall cycles since
    // the last non-stall/clear; block means run >= threshold.
    task automatic step(input logic [1:0] en, input logic [1:0] tv, input logic [1:0] tr,
                        input logic clr, input logic rst);
        exp_t e;
        bit   s;
        bit   ended;
        int   ca, cb;
        e = '0;
        @(negedge clock);
        bus.enable = en;
        bus.tvalid = tv;
        bus.tready = tr;
        clear      = clr;
        reset      = rst;
        for (int i = 0; i < 2; i++) begin
            s = (i == 1) ? (en[i] & tv[i] & ~tr[i]) : (en[i] & tr[i] & ~tv[i]);
            if (rst || clr) begin
                run[i]  = 0;
                mx_a[i] = 0;
                mx_b[i] = 0;
            end else begin
                ca    = (run[i] < 15)  ? run[i] : 15;
                cb    = (run[i] < 255) ? run[i] : 255;
                ended = (run[i] > 0) && !s;
                if (ended || run[i] >= 4) mx_a[i] = imax(mx_a[i], ca);
                if (ended || run[i] >= 1) mx_b[i] = imax(mx_b[i], cb);
                run[i] = s ? ((run[i] < 100000) ? run[i] + 1 : run[i]) : 0;
            end
            e.blk_a[i] = (run[i] >= 4);
            e.blk_b[i] = (run[i] >= 1);
`ifdef AXIS_STALL_HIST_EN
            e.max_a[i*4 +: 4] = 4'(mx_a[i]);
            e.max_b[i*8 +: 8] = 8'(mx_b[i]);
`endif
        end
        e.any_a = |e.blk_a;
        e.any_b = |e.blk_b;
        exp_q.push_back(e);
    endtask

    task automatic repeat_step(input int n, input logic [1:0] en, input logic [1:0] tv,
                               input logic [1:0] tr);
        for (int k = 0; k < n; k++) step(en, tv, tr, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle, so pop one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("blk_a", 32'(blk_a), 32'(e.blk_a));
                check("any_a", 32'(any_a), 32'(e.any_a));
                check("max_a", 32'(max_a), 32'(e.max_a));
                check("blk_b", 32'(blk_b), 32'(e.blk_b));
                check("any_b", 32'(any_b), 32'(e.any_b));
                check("max_b", 32'(max_b), 32'(e.max_b));
            end
        end
    end

    initial begin
        logic [1:0] tv, tr, en;
        logic       clr, rst;
        // Reset state.
        step(2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        // Input ch0 starved 6 cycles, then data arrives.
        repeat_step(6, 2'b11, 2'b00, 2'b01);
        repeat_step(3, 2'b11, 2'b01, 2'b01);
        // Output ch1: 3 stalls, one transfer, 3 stalls.
        repeat_step(3, 2'b11, 2'b10, 2'b00);
        repeat_step(1, 2'b11, 2'b10, 2'b10);
        repeat_step(3, 2'b11, 2'b10, 2'b00);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        // Single stall cycle on ch0.
        repeat_step(1, 2'b11, 2'b00, 2'b01);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        // Both channels stalled, clear in the sixth cycle.
        for (int k = 1; k <= 13; k++) step(2'b11, 2'b10, 2'b01, (k == 6), 1'b0);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        // Disabled channel 0 never stalls.
        repeat_step(20, 2'b10, 2'b00, 2'b01);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        // History runs of 7 and 20 on ch0.
        step(2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
        repeat_step(7, 2'b11, 2'b00, 2'b01);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        repeat_step(20, 2'b11, 2'b00, 2'b01);
        repeat_step(2, 2'b11, 2'b00, 2'b00);
        // Randomised traffic with sticky handshakes to produce long runs.
        tv = 2'b00;
        tr = 2'b00;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) tv = 2'($urandom);
            if ($urandom_range(0, 5) == 0) tr = 2'($urandom);
            en  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
            clr = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step(en, tv, tr, clr, rst);
        end
        repeat (3) @(posedge clock);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
